ransac_inlier_scorer: RTL and testbench

Sequences a fast_point_distance_to_plane instance to score one candidate plane against a stored point cloud. Accepts a plane and threshold, streams point addresses to the point memory at 1 per cycle and feeds returned points into the distance datapath. Counts results with distance <= threshold and reports the inlier count through a valid/ready handshake. Sits between the plane-hypothesis generator and the best-model selector in the RANSAC loop.

---
 rtl/ransac_inlier_scorer.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_ransac_inlier_scorer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ransac_inlier_scorer.sv
// RANSAC inlier scorer: streams a stored point cloud through a pipelined
// point-to-plane distance unit and counts points lying within a threshold.

package ransac_fixed;
    localparam int value_width = 32;
    localparam int frac_bits   = 16;

    function automatic int value_bits();
        return value_width;
    endfunction

    // Signed Q15.16 fixed point.
    typedef logic signed [value_width-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } point_t;

    typedef struct packed {
        point_t normal;
        fixed_t d;
    } plane_t;

    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic [value_width+frac_bits-1:0] prod;
        prod = {{frac_bits{a[value_width-1]}}, a} * {{frac_bits{b[value_width-1]}}, b};
        return fixed_t'(prod >> frac_bits);
    endfunction
endpackage

// |n.p + d| with multiply_latency product stages, then a sum stage and an
// absolute-value stage that are registered when addition_has_latency is set.
module fast_point_distance_to_plane #(
    parameter int multiply_latency     = 4,
    parameter int addition_has_latency = 1,
    parameter int pipeline_bits        = 1
) (
    input  logic                      clock,
    input  ransac_fixed::plane_t      plane,
    input  ransac_fixed::point_t      point,
    input  logic [pipeline_bits-1:0]  pipeline_i,
    output ransac_fixed::fixed_t      distance,
    output logic [pipeline_bits-1:0]  pipeline_o
);
    import ransac_fixed::*;

    typedef struct packed {
        logic [pipeline_bits-1:0] pipe;
        fixed_t                   px;
        fixed_t                   py;
        fixed_t                   pz;
    } mul_stage_t;

    mul_stage_t mul_d;
    mul_stage_t mul_q [multiply_latency];

    fixed_t                   sum_d;
    fixed_t                   sum_v;
    logic [pipeline_bits-1:0] sum_pipe_v;
    fixed_t                   abs_d;
    fixed_t                   abs_v;
    logic [pipeline_bits-1:0] abs_pipe_v;

    always_comb begin
        mul_d.pipe = pipeline_i;
        mul_d.px   = fx_mul(plane.normal.x, point.x);
        mul_d.py   = fx_mul(plane.normal.y, point.y);
        mul_d.pz   = fx_mul(plane.normal.z, point.z);
    end

    // Datapath registers carry no reset; the owner flushes them by waiting.
    always_ff @(posedge clock) begin
        mul_q[0] <= mul_d;
        for (int i = 1; i < multiply_latency; i++) begin
            mul_q[i] <= mul_q[i-1];
        end
    end

    always_comb begin
        sum_d = mul_q[multiply_latency-1].px + mul_q[multiply_latency-1].py
              + mul_q[multiply_latency-1].pz + plane.d;
    end

    always_comb begin
        abs_d = sum_v[value_width-1] ? -sum_v : sum_v;
    end

    generate
        if (addition_has_latency != 0) begin : g_add_regs
            fixed_t                   sum_q;
            fixed_t                   abs_q;
            logic [pipeline_bits-1:0] sum_pipe_q;
            logic [pipeline_bits-1:0] abs_pipe_q;

            always_ff @(posedge clock) begin
                sum_q      <= sum_d;
                sum_pipe_q <= mul_q[multiply_latency-1].pipe;
                abs_q      <= abs_d;
                abs_pipe_q <= sum_pipe_q;
            end

            assign sum_v      = sum_q;
            assign sum_pipe_v = sum_pipe_q;
            assign abs_v      = abs_q;
            assign abs_pipe_v = abs_pipe_q;
        end else begin : g_add_comb
            assign sum_v      = sum_d;
            assign sum_pipe_v = mul_q[multiply_latency-1].pipe;
            assign abs_v      = abs_d;
            assign abs_pipe_v = sum_pipe_v;
        end
    endgenerate

    assign distance   = abs_v;
    assign pipeline_o = abs_pipe_v;
endmodule

// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high; the plane side is only ready in IDLE, the score is held in DONE.
module ransac_inlier_scorer #(
    parameter int count_bits           = 16,
    parameter int memory_read_latency  = 1,
    parameter int multiply_latency     = ransac_fixed::value_bits() / 8,
    parameter int addition_has_latency = 1,
    parameter int flush_cycles         = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    plane_valid,
    output logic                    plane_ready,
    input  ransac_fixed::plane_t    plane,
    input  ransac_fixed::fixed_t    threshold,
    input  logic [count_bits-1:0]   point_count,
    output logic                    mem_read,
    output logic [count_bits-1:0]   mem_addr,
    input  ransac_fixed::point_t    mem_point,
    output logic                    score_valid,
    input  logic                    score_ready,
    output logic [count_bits-1:0]   score,
    output logic                    busy,
    output logic [2:0]              dbg_state
);
    import ransac_fixed::*;

    localparam int flush_bits = $clog2(flush_cycles + 1);
    localparam logic [count_bits-1:0] count_one    = 1;
    localparam logic [count_bits:0]   inflight_one = 1;
    localparam logic [flush_bits-1:0] flush_one    = 1;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [flush_bits-1:0]         flush_cnt_q, flush_cnt_d;
    plane_t                        plane_q, plane_d;
    fixed_t                        threshold_q, threshold_d;
    logic [count_bits-1:0]         count_q, count_d;
    logic [count_bits-1:0]         mem_addr_q, mem_addr_d;
    logic [count_bits-1:0]         score_q, score_d;
    logic [count_bits-1:0]         inlier_q, inlier_d;
    logic [count_bits:0]           inflight_q, inflight_d;
    logic                          plane_ready_q, plane_ready_d;
    logic                          mem_read_q, mem_read_d;
    logic                          score_valid_q, score_valid_d;
    logic                          busy_q, busy_d;
    logic [memory_read_latency-1:0] rd_valid_q, rd_valid_d;

    fixed_t distance;
    logic   result_pipe;
    logic   result;

    fast_point_distance_to_plane #(
        .multiply_latency     (multiply_latency),
        .addition_has_latency (addition_has_latency),
        .pipeline_bits        (1)
    ) u_distance (
        .clock      (clock),
        .plane      (plane_q),
        .point      (mem_point),
        .pipeline_i (rd_valid_q[memory_read_latency-1]),
        .distance   (distance),
        .pipeline_o (result_pipe)
    );

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        plane_d       = plane_q;
        threshold_d   = threshold_q;
        count_d       = count_q;
        mem_addr_d    = mem_addr_q;
        score_d       = score_q;
        inlier_d      = inlier_q;
        inflight_d    = inflight_q;
        plane_ready_d = plane_ready_q;
        mem_read_d    = mem_read_q;
        score_valid_d = score_valid_q;
        busy_d        = busy_q;

        // Read strobe delayed to line up with the memory's returned data.
        rd_valid_d = memory_read_latency'({rd_valid_q, mem_read_q});

        // Results leaving the pipe during FLUSH/IDLE are stale and never counted.
        result = result_pipe && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

        if (mem_read_q && !result) begin
            inflight_d = inflight_q + inflight_one;
        end else if (!mem_read_q && result) begin
            inflight_d = inflight_q - inflight_one;
        end

        if (result && (distance <= threshold_q)) begin
            inlier_d = inlier_q + count_one;
        end

        case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q <= flush_one) begin
                    flush_cnt_d   = '0;
                    state_d       = ST_IDLE;
                    plane_ready_d = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - flush_one;
                end
            end
            ST_IDLE: begin
                if (plane_valid && plane_ready_q) begin
                    plane_d       = plane;
                    threshold_d   = threshold;
                    count_d       = point_count;
                    inlier_d      = '0;
                    mem_addr_d    = '0;
                    plane_ready_d = 1'b0;
                    busy_d        = 1'b1;
                    if (point_count == '0) begin
                        score_d       = '0;
                        score_valid_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        mem_read_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_addr_q == count_q - count_one) begin
                    mem_read_d = 1'b0;
                    state_d    = ST_DRAIN;
                end else begin
                    mem_addr_d = mem_addr_q + count_one;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && !result) begin
                    score_d       = inlier_q;
                    score_valid_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (score_ready) begin
                    score_valid_d = 1'b0;
                    plane_ready_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= flush_bits'(flush_cycles);
            plane_q       <= '0;
            threshold_q   <= '0;
            count_q       <= '0;
            mem_addr_q    <= '0;
            score_q       <= '0;
            inlier_q      <= '0;
            inflight_q    <= '0;
            plane_ready_q <= 1'b0;
            mem_read_q    <= 1'b0;
            score_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            rd_valid_q    <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            plane_q       <= plane_d;
            threshold_q   <= threshold_d;
            count_q       <= count_d;
            mem_addr_q    <= mem_addr_d;
            score_q       <= score_d;
            inlier_q      <= inlier_d;
            inflight_q    <= inflight_d;
            plane_ready_q <= plane_ready_d;
            mem_read_q    <= mem_read_d;
            score_valid_q <= score_valid_d;
            busy_q        <= busy_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign plane_ready = plane_ready_q;
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign score_valid = score_valid_q;
    assign score       = score_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_ransac_inlier_scorer.sv
// Bench for ransac_inlier_scorer: memory responder, job driver tasks, one task
// per scenario and a point-to-plane reference computed from plain arithmetic.
`timescale 1ns/1ps
module tb_ransac_inlier_scorer;
    import ransac_fixed::*;

    localparam int CW      = 16;
    localparam int MEM_LAT = 1;
    localparam int DP_LAT  = 32 / 8 + 2;
    localparam int FLUSH   = 16;

    logic           clock;
    logic           reset_n;
    logic           plane_valid;
    logic           plane_ready;
    plane_t         plane;
    fixed_t         threshold;
    logic [CW-1:0]  point_count;
    logic           mem_read;
    logic [CW-1:0]  mem_addr;
    point_t         mem_point;
    logic           score_valid;
    logic           score_ready;
    logic [CW-1:0]  score;
    logic           busy;
    logic [2:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    point_t        mem_arr [0:255];
    logic [CW-1:0] rd_q[$];
    int            rd_cyc_q[$];
    logic [CW-1:0] exp_q[$];

    ransac_inlier_scorer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .plane_valid (plane_valid),
        .plane_ready (plane_ready),
        .plane       (plane),
        .threshold   (threshold),
        .point_count (point_count),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_point   (mem_point),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score       (score),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / responders / monitor ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_read) mem_point <= mem_arr[mem_addr[7:0]];
    end

    always @(negedge clock) begin
        if (mem_read === 1'b1) begin
            rd_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic fixed_t fx(input real r);
        return fixed_t'($rtoi(r * 65536.0));
    endfunction

    function automatic fixed_t rand_fx(input int span);
        return fixed_t'(int'($urandom_range(0, 2 * span)) - span);
    endfunction

    function automatic plane_t make_plane(input real nx, input real ny, input real nz, input real d);
        plane_t p;
        p.normal.x = fx(nx);
        p.normal.y = fx(ny);
        p.normal.z = fx(nz);
        p.d        = fx(d);
        return p;
    endfunction

    function automatic plane_t rand_plane();
        plane_t p;
        p.normal.x = rand_fx(65536);
        p.normal.y = rand_fx(65536);
        p.normal.z = rand_fx(65536);
        p.d        = rand_fx(8 * 65536);
        return p;
    endfunction

    // Count of stored points whose |n.p + d| (products floored to Q16) <= thr.
    function automatic int ref_score(input plane_t p, input fixed_t thr, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            fixed_t nx, ny, nz, pd, x, y, z;
            longint dot;
            nx = p.normal.x; ny = p.normal.y; nz = p.normal.z; pd = p.d;
            x = mem_arr[i].x; y = mem_arr[i].y; z = mem_arr[i].z;
            dot = ((longint'(nx) * longint'(x)) >>> 16) + ((longint'(ny) * longint'(y)) >>> 16)
                + ((longint'(nz) * longint'(z)) >>> 16) + longint'(pd);
            if (dot < 0) dot = -dot;
            if (dot <= longint'(thr)) cnt++;
        end
        return cnt;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            mem_arr[i].x = rand_fx(16 * 65536);
            mem_arr[i].y = rand_fx(16 * 65536);
            mem_arr[i].z = rand_fx(16 * 65536);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input plane_t p, input fixed_t thr, input int n,
                             output int waits, output bit to);
        bit acc;
        bit accepted;
        plane       = p;
        threshold   = thr;
        point_count = CW'(n);
        plane_valid = 1'b1;
        waits = 0;
        accepted = 0;
        to = 0;
        while (!accepted && waits < 50) begin
            acc = plane_ready;
            @(posedge clock);
            waits++;
            @(negedge clock);
            score_ready = 1'b0;
            if (acc) accepted = 1;
        end
        plane_valid = 1'b0;
        if (!accepted) to = 1;
    endtask

    task automatic wait_score(output int lat, output bit to);
        lat = 0;
        to = 0;
        while (score_valid !== 1'b1) begin
            if (lat >= 400) begin
                to = 1;
                break;
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic ack_score();
        score_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        score_ready = 1'b0;
    endtask

    task automatic read_stats(output int nrd, output int bad_addr, output int span);
        nrd = rd_q.size();
        bad_addr = 0;
        for (int i = 0; i < nrd; i++) begin
            if (rd_q[i] != CW'(i)) bad_addr++;
        end
        span = (nrd > 0) ? (rd_cyc_q[nrd-1] - rd_cyc_q[0]) : 0;
    endtask

    task automatic measure_flush(output int low, output int bad_sv, output int bad_rd);
        low = 0;
        bad_sv = 0;
        bad_rd = 0;
        while (plane_ready !== 1'b1 && low < 100) begin
            if (score_valid !== 1'b0) bad_sv++;
            if (mem_read !== 1'b0) bad_rd++;
            low++;
            @(negedge clock);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int low, bad_sv, bad_rd;
        reset_n = 1'b0;
        plane_valid = 1'b0;
        score_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", busy); end
        checks++; if (plane_ready !== 1'b0) begin errors++; $display("FAIL reset_plane_ready: got %0b expected 0", plane_ready); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL reset_score_valid: got %0b expected 0", score_valid); end
        checks++; if (score !== '0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if (mem_read !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem: got read=%0b addr=%0d expected 0/0", mem_read, mem_addr); end
        reset_n = 1'b1;
        measure_flush(low, bad_sv, bad_rd);
        checks++; if (low != FLUSH) begin errors++; $display("FAIL flush_len: got %0d cycles expected %0d", low, FLUSH); end
        checks++; if (bad_sv != 0) begin errors++; $display("FAIL flush_score_valid: got %0d cycles high expected 0", bad_sv); end
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL flush_mem_read: got %0d cycles high expected 0", bad_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_basic();
        real zs[8] = '{0.0, 0.5, -0.5, 1.0, -1.0, 1.5, 2.0, -3.0};
        int waits, lat, nrd, bad_addr, span;
        bit to1, to2;
        for (int i = 0; i < 8; i++) begin
            mem_arr[i].x = fixed_t'($urandom);
            mem_arr[i].y = fixed_t'($urandom);
            mem_arr[i].z = fx(zs[i]);
        end
        rd_q.delete(); rd_cyc_q.delete();
        start_job(make_plane(0.0, 0.0, 1.0, 0.0), fx(1.0), 8, waits, to1);
        wait_score(lat, to2);
        read_stats(nrd, bad_addr, span);
        checks++; if (to1 || to2) begin errors++; $display("FAIL basic_timeout: got accept_to=%0b score_to=%0b expected 0/0", to1, to2); end
        checks++; if (score !== CW'(5)) begin errors++; $display("FAIL basic_score: got %0d expected 5", score); end
        checks++; if (lat != 8 + MEM_LAT + DP_LAT + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 8 + MEM_LAT + DP_LAT + 1); end
        checks++; if (nrd != 8) begin errors++; $display("FAIL basic_reads: got %0d expected 8", nrd); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL basic_addr_order: got %0d wrong expected 0", bad_addr); end
        checks++; if (span != 7) begin errors++; $display("FAIL basic_contiguous: got span %0d expected 7", span); end
        ack_score();
        checks++; if (score !== CW'(5) || score_valid !== 1'b0) begin errors++; $display("FAIL basic_hold: got score=%0d valid=%0b expected 5/0", score, score_valid); end
    endtask

    task automatic test_zero_count();
        int waits, lat, nrd, bad_addr, span;
        bit to1, to2;
        rd_q.delete(); rd_cyc_q.delete();
        start_job(rand_plane(), fx(100.0), 0, waits, to1);
        wait_score(lat, to2);
        read_stats(nrd, bad_addr, span);
        checks++; if (to1 || to2) begin errors++; $display("FAIL zero_timeout: got accept_to=%0b score_to=%0b expected 0/0", to1, to2); end
        checks++; if (score !== '0) begin errors++; $display("FAIL zero_score: got %0d expected 0", score); end
        checks++; if (lat != 0) begin errors++; $display("FAIL zero_latency: got %0d expected 0", lat); end
        checks++; if (nrd != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", nrd); end
        ack_score();
        checks++; if (plane_ready !== 1'b1 || score_valid !== 1'b0) begin errors++; $display("FAIL zero_return_idle: got ready=%0b valid=%0b expected 1/0", plane_ready, score_valid); end
    endtask

    task automatic test_backpressure();
        int waits, lat, exp, bad_sv, bad_sc, bad_pr, bad_st;
        bit to1, to2;
        plane_t p;
        fixed_t thr;
        logic [2:0] st0;
        fill_random(12);
        p = rand_plane();
        thr = fixed_t'($urandom_range(0, 24 * 65536));
        exp = ref_score(p, thr, 12);
        start_job(p, thr, 12, waits, to1);
        wait_score(lat, to2);
        checks++; if (to1 || to2) begin errors++; $display("FAIL bp_timeout: got accept_to=%0b score_to=%0b expected 0/0", to1, to2); end
        checks++; if (score !== CW'(exp)) begin errors++; $display("FAIL bp_score: got %0d expected %0d", score, exp); end
        rd_q.delete(); rd_cyc_q.delete();
        bad_sv = 0; bad_sc = 0; bad_pr = 0; bad_st = 0;
        st0 = dbg_state;
        plane = rand_plane();
        point_count = CW'(5);
        plane_valid = 1'b1;
        score_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (score_valid !== 1'b1) bad_sv++;
            if (score !== CW'(exp)) bad_sc++;
            if (plane_ready !== 1'b0) bad_pr++;
            if (dbg_state !== st0) bad_st++;
        end
        plane_valid = 1'b0;
        checks++; if (bad_sv != 0) begin errors++; $display("FAIL bp_valid_held: got %0d drops expected 0", bad_sv); end
        checks++; if (bad_sc != 0) begin errors++; $display("FAIL bp_score_held: got %0d changes expected 0", bad_sc); end
        checks++; if (bad_pr != 0) begin errors++; $display("FAIL bp_plane_ready: got %0d cycles high expected 0", bad_pr); end
        checks++; if (bad_st != 0 || rd_q.size() != 0) begin errors++; $display("FAIL bp_plane_ignored: got state_changes=%0d reads=%0d expected 0/0", bad_st, rd_q.size()); end
        ack_score();
        checks++; if (plane_ready !== 1'b1) begin errors++; $display("FAIL bp_return_idle: got %0b expected 1", plane_ready); end
    endtask

    task automatic test_back_to_back();
        int waits, lat, exp1, exp2, nrd, bad_addr, span, n2;
        bit to1, to2;
        plane_t p1, p2;
        fixed_t t1, t2;
        fill_random(10);
        p1 = rand_plane();
        t1 = fixed_t'($urandom_range(8 * 65536, 24 * 65536));
        exp1 = ref_score(p1, t1, 10);
        start_job(p1, t1, 10, waits, to1);
        wait_score(lat, to2);
        checks++; if (to1 || to2 || score !== CW'(exp1)) begin errors++; $display("FAIL b2b_first: got score=%0d to=%0b%0b expected %0d", score, to1, to2, exp1); end
        n2 = int'($urandom_range(3, 20));
        fill_random(n2);
        p2 = rand_plane();
        t2 = fixed_t'($urandom_range(0, 24 * 65536));
        exp2 = ref_score(p2, t2, n2);
        rd_q.delete(); rd_cyc_q.delete();
        score_ready = 1'b1;
        start_job(p2, t2, n2, waits, to1);
        checks++; if (to1 || waits != 2) begin errors++; $display("FAIL b2b_accept_cycle: got %0d edges expected 2", waits); end
        wait_score(lat, to2);
        read_stats(nrd, bad_addr, span);
        checks++; if (to2 || score !== CW'(exp2)) begin errors++; $display("FAIL b2b_second: got score=%0d to=%0b expected %0d", score, to2, exp2); end
        checks++; if (nrd != n2 || bad_addr != 0 || span != n2 - 1) begin errors++; $display("FAIL b2b_reads: got n=%0d bad=%0d span=%0d expected %0d/0/%0d", nrd, bad_addr, span, n2, n2 - 1); end
        ack_score();
    endtask

    task automatic test_reset_mid_issue();
        int waits, lat, guard, low, bad_sv, bad_rd;
        bit to1, to2;
        real zs[4] = '{0.0, 0.25, -0.75, 1.0};
        for (int i = 0; i < 100; i++) begin
            mem_arr[i].x = rand_fx(16 * 65536);
            mem_arr[i].y = rand_fx(16 * 65536);
            mem_arr[i].z = fx(0.5);
        end
        start_job(make_plane(0.0, 0.0, 1.0, 0.0), fx(1.0), 100, waits, to1);
        guard = 0;
        while (!(mem_read === 1'b1 && mem_addr == CW'(3)) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        checks++; if (to1 || guard >= 50) begin errors++; $display("FAIL mid_reach_addr3: got guard=%0d to=%0b expected <50/0", guard, to1); end
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        measure_flush(low, bad_sv, bad_rd);
        checks++; if (low != FLUSH) begin errors++; $display("FAIL mid_flush_len: got %0d expected %0d", low, FLUSH); end
        checks++; if (bad_sv != 0 || bad_rd != 0) begin errors++; $display("FAIL mid_flush_quiet: got valid=%0d reads=%0d expected 0/0", bad_sv, bad_rd); end
        for (int i = 0; i < 4; i++) mem_arr[i].z = fx(zs[i]);
        start_job(make_plane(0.0, 0.0, 1.0, 0.0), fx(1.0), 4, waits, to1);
        wait_score(lat, to2);
        checks++; if (to1 || to2 || score !== CW'(4)) begin errors++; $display("FAIL mid_next_job: got score=%0d to=%0b%0b expected 4", score, to1, to2); end
        ack_score();
    endtask

    task automatic test_random();
        int waits, lat, n, nrd, bad_addr, span;
        bit to1, to2;
        plane_t p;
        fixed_t thr;
        logic [CW-1:0] exp;
        for (int j = 0; j < 6; j++) begin
            n = int'($urandom_range(1, 40));
            fill_random(n);
            p = rand_plane();
            thr = fixed_t'($urandom_range(0, 24 * 65536));
            exp_q.push_back(CW'(ref_score(p, thr, n)));
            rd_q.delete(); rd_cyc_q.delete();
            start_job(p, thr, n, waits, to1);
            wait_score(lat, to2);
            read_stats(nrd, bad_addr, span);
            exp = exp_q.pop_front();
            checks++; if (to1 || to2 || score !== exp) begin errors++; $display("FAIL rand_score[%0d]: got %0d expected %0d (n=%0d)", j, score, exp, n); end
            checks++; if (lat != n + MEM_LAT + DP_LAT + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", j, lat, n + MEM_LAT + DP_LAT + 1); end
            checks++; if (nrd != n || bad_addr != 0 || span != n - 1) begin errors++; $display("FAIL rand_reads[%0d]: got n=%0d bad=%0d span=%0d expected %0d/0/%0d", j, nrd, bad_addr, span, n, n - 1); end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            ack_score();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        plane_valid = 1'b0;
        score_ready = 1'b0;
        plane = '0;
        threshold = '0;
        point_count = '0;
        mem_point = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
